// File: rtl/ipv4_pkg.sv
// Shared IPv4 receive definitions: header constants, word indices, FSM states, header record.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ipv4_pkg;

    localparam logic [3:0]  IPV4_VERSION = 4'd4;
    localparam logic [3:0]  IHL_MIN      = 4'd5;
    localparam logic [7:0]  PROTO_UDP    = 8'd17;
    localparam logic [15:0] CSUM_OK      = 16'hFFFF;

    // 16-bit header word indices, counted from the first byte of the IPv4 header
    localparam logic [4:0] W_TOTLEN = 5'd1;
    localparam logic [4:0] W_FLAGS  = 5'd3;
    localparam logic [4:0] W_PROTO  = 5'd4;
    localparam logic [4:0] W_SRC_HI = 5'd6;
    localparam logic [4:0] W_SRC_LO = 5'd7;
    localparam logic [4:0] W_DST_HI = 5'd8;
    localparam logic [4:0] W_DST_LO = 5'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } ipv4_fsm_e;

    // Only the header fields that the validity check or the outputs need
    typedef struct packed {
        logic [3:0]  version;
        logic [3:0]  ihl;
        logic [15:0] totlen;
        logic        mf;
        logic [12:0] frag_off;
        logic [7:0]  proto;
        logic [15:0] src_hi;
        logic [15:0] src_lo;
        logic [15:0] dst_hi;
        logic [15:0] dst_lo;
    } hdr_t;

    // Ones-complement 16-bit add with end-around carry. After folding the
    // carry the result cannot carry again, so one fold is enough.
    function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/ipv4_csum.sv
// Ones-complement running sum of IPv4 header words.
// Latency: sum_o reflects words accepted up to the previous clock edge.
// Backpressure: none; en_i low holds the sum.
//
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   clr_i       restart the sum (loads word_i when en_i is also high, else zero)
//   en_i        accumulate word_i this cycle
//   word_i      16-bit header word
//   sum_o       registered running sum
module ipv4_csum
    import ipv4_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [15:0] word_i,
    output logic [15:0] sum_o
);

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_o <= 16'h0000;
        end else if (clr_i) begin
            sum_o <= en_i ? word_i : 16'h0000;
        end else if (en_i) begin
            sum_o <= csum_add(sum_o, word_i);
        end
    end

endmodule

// File: rtl/ipv4_rx.sv
// IPv4 receive: validates and strips the IPv4 header, trims pad/FCS by total length, forwards the L4 payload.
// Latency: 1 cycle from accepted input beat to output beat; all outputs registered.
// Backpressure: none; valid_i low freezes all state, there is no ready.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   valid_i/start_i   MAC payload beat valid / first beat (IPv4 word 0)
//   data_i, len_i     beat data (data_i[15:8] earlier on the wire), valid byte count
//   crc_err_i         MAC FCS error pulse at frame end
//   valid_o/start_o/last_o, data_o, len_o   L4 payload beats with framing
//   err_o             1-cycle pulse: discard the packet being / just forwarded
//   src_ip_o/dst_ip_o addresses, stable from start_o until the next start_o
module ipv4_rx
    import ipv4_pkg::*;
#(
    parameter int         DATA_W = 16,
    parameter int         LEN_W  = $clog2(DATA_W/8+1),
    parameter logic [7:0] PROTO  = PROTO_UDP
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              crc_err_i,
    output logic              valid_o,
    output logic              start_o,
    output logic              last_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              err_o,
    output logic [31:0]       src_ip_o,
    output logic [31:0]       dst_ip_o
);

    if (DATA_W != 16) begin : g_bad_width
        $error("ipv4_rx: only DATA_W=16 is supported");
    end

    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DATA_W/8);

    ipv4_fsm_e   state_q;
    hdr_t        hdr_q;
    logic [4:0]  hdr_cnt_q;   // index of the header word on data_i while in HEAD
    logic [15:0] rem_q;       // payload bytes still to forward
    logic        first_q;     // next DATA beat carries start_o
    logic        fwd_q;       // a complete packet was forwarded; a late FCS error still applies

    logic [15:0] csum_q;
    logic        csum_clr;
    logic        csum_en;

    // Checksum restarts on every start beat (including aborts) and runs through the header
    assign csum_clr = valid_i & start_i;
    assign csum_en  = valid_i & (start_i | (state_q == HEAD));

    ipv4_csum u_csum (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (csum_clr),
        .en_i   (csum_en),
        .word_i (data_i),
        .sum_o  (csum_q)
    );

    // Header evaluation, combinational on the last header word
    logic [4:0]  last_idx;
    logic [15:0] hdr_bytes;
    logic [15:0] dst_lo_cur;
    logic [15:0] csum_fin;
    logic        hdr_ok;
    logic        has_pay;
    logic [15:0] pay_len;
    logic        short_beat;
    logic [LEN_W-1:0] beat_len;

    // With IHL<5 the header is still walked to word 9, where the IHL check rejects it;
    // this keeps IHL*2-1 from underflowing.
    assign last_idx   = (hdr_q.ihl < IHL_MIN) ? W_DST_LO : ({hdr_q.ihl, 1'b0} - 5'd1);
    assign hdr_bytes  = 16'({hdr_q.ihl, 2'b00});
    // With IHL=5 the last header word is the low half of the destination address
    assign dst_lo_cur = (hdr_cnt_q == W_DST_LO) ? data_i : hdr_q.dst_lo;
    assign csum_fin   = csum_add(csum_q, data_i);
    assign hdr_ok     = (hdr_q.version == IPV4_VERSION) &&
                        (hdr_q.ihl >= IHL_MIN) &&
                        (hdr_q.totlen >= hdr_bytes) &&
                        !hdr_q.mf &&
                        (hdr_q.frag_off == 13'd0) &&
                        (hdr_q.proto == PROTO) &&
                        (csum_fin == CSUM_OK);
    assign has_pay    = hdr_q.totlen > hdr_bytes;
    assign pay_len    = hdr_q.totlen - hdr_bytes;
    assign short_beat = len_i < LEN_FULL;
    assign beat_len   = (rem_q >= 16'(LEN_FULL)) ? LEN_FULL : rem_q[LEN_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            hdr_q     <= '0;
            hdr_cnt_q <= 5'd0;
            rem_q     <= 16'd0;
            first_q   <= 1'b0;
            fwd_q     <= 1'b0;
            valid_o   <= 1'b0;
            start_o   <= 1'b0;
            last_o    <= 1'b0;
            err_o     <= 1'b0;
            data_o    <= '0;
            len_o     <= '0;
            src_ip_o  <= 32'd0;
            dst_ip_o  <= 32'd0;
        end else begin
            valid_o <= 1'b0;
            start_o <= 1'b0;
            last_o  <= 1'b0;
            err_o   <= 1'b0;

            // FCS error hits the packet in flight or the one just completed.
            // Evaluated ahead of start_i so a same-cycle start only affects the new packet.
            if (crc_err_i && ((state_q == DATA) || fwd_q)) begin
                err_o <= 1'b1;
                fwd_q <= 1'b0;
            end

            if (valid_i && start_i) begin
                // Start from any state; aborting a packet mid-payload flags it
                if (state_q == DATA) begin
                    err_o <= 1'b1;
                end
                fwd_q         <= 1'b0;
                hdr_q.version <= data_i[15:12];
                hdr_q.ihl     <= data_i[11:8];
                hdr_cnt_q     <= 5'd1;
                state_q       <= short_beat ? DROP : HEAD;
            end else if (crc_err_i && (state_q == DATA)) begin
                state_q <= IDLE;
            end else if (valid_i) begin
                case (state_q)
                    HEAD: begin
                        hdr_cnt_q <= hdr_cnt_q + 5'd1;
                        case (hdr_cnt_q)
                            W_TOTLEN: hdr_q.totlen <= data_i;
                            W_FLAGS: begin
                                hdr_q.mf       <= data_i[13];
                                hdr_q.frag_off <= data_i[12:0];
                            end
                            W_PROTO:  hdr_q.proto  <= data_i[7:0];
                            W_SRC_HI: hdr_q.src_hi <= data_i;
                            W_SRC_LO: hdr_q.src_lo <= data_i;
                            W_DST_HI: hdr_q.dst_hi <= data_i;
                            W_DST_LO: hdr_q.dst_lo <= data_i;
                            default: ;
                        endcase
                        if (short_beat) begin
                            state_q <= DROP;
                        end else if (hdr_cnt_q == last_idx) begin
                            if (hdr_ok && has_pay) begin
                                state_q  <= DATA;
                                rem_q    <= pay_len;
                                first_q  <= 1'b1;
                                src_ip_o <= {hdr_q.src_hi, hdr_q.src_lo};
                                dst_ip_o <= {hdr_q.dst_hi, dst_lo_cur};
                            end else begin
                                state_q <= DROP;
                            end
                        end
                    end
                    DATA: begin
                        if (short_beat && (rem_q > 16'(len_i))) begin
                            // MAC frame ended before total length was reached
                            err_o   <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            valid_o <= 1'b1;
                            start_o <= first_q;
                            first_q <= 1'b0;
                            data_o  <= data_i;
                            len_o   <= beat_len;
                            rem_q   <= rem_q - 16'(beat_len);
                            if (rem_q <= 16'(LEN_FULL)) begin
                                last_o  <= 1'b1;
                                fwd_q   <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                    end
                    // IDLE/DROP: non-start beats (pad, FCS, rejected packets) are ignored
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ipv4_rx.sv
// Bench for ipv4_rx: directed frames, expected output beats queued at stimulus time,
// monitor compares every output event against the queue head.
module tb_ipv4_rx;

    localparam logic [31:0] SRC = 32'hc0a80001;
    localparam logic [31:0] DST = 32'hc0a800c7;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic        start_i;
    logic [15:0] data_i;
    logic [1:0]  len_i;
    logic        crc_err_i;
    logic        valid_o;
    logic        start_o;
    logic        last_o;
    logic [15:0] data_o;
    logic [1:0]  len_o;
    logic        err_o;
    logic [31:0] src_ip_o;
    logic [31:0] dst_ip_o;

    always #5 clk = ~clk;

    ipv4_rx dut (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .start_i   (start_i),
        .data_i    (data_i),
        .len_i     (len_i),
        .crc_err_i (crc_err_i),
        .valid_o   (valid_o),
        .start_o   (start_o),
        .last_o    (last_o),
        .data_o    (data_o),
        .len_o     (len_o),
        .err_o     (err_o),
        .src_ip_o  (src_ip_o),
        .dst_ip_o  (dst_ip_o)
    );

    typedef struct packed {
        logic        err;
        logic        st;
        logic        lst;
        logic [15:0] dat;
        logic [1:0]  len;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] hdr [0:15];
    int          hdr_n = 0;
    logic        gap_en = 1'b0;

    function automatic logic [7:0] pb(input int k);
        return 8'(k * 7 + 3);
    endfunction

    function automatic exp_t mk_beat(input logic st, input logic lst, input logic [15:0] d, input logic [1:0] l);
        exp_t e;
        e.err = 1'b0; e.st = st; e.lst = lst; e.dat = d; e.len = l;
        return e;
    endfunction

    function automatic exp_t mk_err();
        exp_t e;
        e = '0;
        e.err = 1'b1;
        return e;
    endfunction

    // Monitor: every cycle with valid_o or err_o consumes one expected event
    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (!reset && (valid_o || err_o)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got vld=%0b err=%0b dat=%h, required no output", valid_o, err_o, data_o);
            end else begin
                e = exp_q.pop_front();
                if (e.err) ok = err_o && !valid_o;
                else ok = valid_o && !err_o && (start_o == e.st) && (last_o == e.lst) &&
                          (data_o == e.dat) && (len_o == e.len);
                if (!ok) begin
                    errors++;
                    $display("FAIL out_event: got vld=%0b err=%0b st=%0b lst=%0b dat=%h len=%0d, required err=%0b st=%0b lst=%0b dat=%h len=%0d",
                             valid_o, err_o, start_o, last_o, data_o, len_o, e.err, e.st, e.lst, e.dat, e.len);
                end
                if (!e.err && e.st) begin
                    checks++;
                    if (src_ip_o !== SRC || dst_ip_o !== DST) begin
                        errors++;
                        $display("FAIL addr: got src=%h dst=%h, required src=%h dst=%h", src_ip_o, dst_ip_o, SRC, DST);
                    end
                end
            end
        end
    end

    task automatic beat(input logic st, input logic [15:0] d, input logic [1:0] l);
        @(negedge clk);
        valid_i = 1'b1; start_i = st; data_i = d; len_i = l; crc_err_i = 1'b0;
        if (gap_en) begin
            // Idle cycle with junk on the bus: must not disturb anything
            @(negedge clk);
            valid_i = 1'b0; start_i = 1'b1; data_i = 16'hdead; len_i = 2'd0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_i = 1'b0; start_i = 1'b0; crc_err_i = 1'b0;
        end
    endtask

    task automatic crc_pulse();
        @(negedge clk);
        valid_i = 1'b0; start_i = 1'b0; crc_err_i = 1'b1;
        @(negedge clk);
        crc_err_i = 1'b0;
    endtask

    task automatic load_std(input logic [15:0] tot, input logic [15:0] fl, input logic [15:0] pw, input logic [15:0] ck);
        hdr[0] = 16'h4500; hdr[1] = tot;         hdr[2] = 16'h0000; hdr[3] = fl;
        hdr[4] = pw;       hdr[5] = ck;          hdr[6] = 16'hc0a8; hdr[7] = 16'h0001;
        hdr[8] = 16'hc0a8; hdr[9] = 16'h00c7;
        hdr_n = 10;
    endtask

    // Drive header + pay payload bytes + extra trailing bytes. fwd: payload expected out.
    // stop_pay>=0 stops before that payload beat; mode 2 then sends a 1-byte tail (truncation).
    task automatic send_frame(input int pay, input int extra, input logic fwd, input int stop_pay, input int mode);
        int          total;
        logic [15:0] w;
        logic [1:0]  l;
        total = pay + extra;
        for (int i = 0; i < hdr_n; i++) beat(i == 0, hdr[i], 2'd2);
        for (int j = 0; 2*j < total; j++) begin
            if (stop_pay >= 0 && j == stop_pay) begin
                if (mode == 2) begin
                    exp_q.push_back(mk_err());
                    beat(1'b0, {pb(2*j), 8'h00}, 2'd1);
                end
                break;
            end
            w = {pb(2*j), (2*j+1 < total) ? pb(2*j+1) : 8'h00};
            l = (total - 2*j >= 2) ? 2'd2 : 2'd1;
            if (fwd && 2*j < pay)
                exp_q.push_back(mk_beat(j == 0, 2*j+2 >= pay, w, (pay - 2*j >= 2) ? 2'd2 : 2'd1));
            beat(1'b0, w, l);
        end
    endtask

    task automatic check_reset(input string name);
        checks++;
        if ({valid_o, start_o, last_o, err_o, len_o} !== 6'd0) begin
            errors++;
            $display("FAIL %s_ctrl: got vld=%0b st=%0b lst=%0b err=%0b len=%0d, required all 0",
                     name, valid_o, start_o, last_o, err_o, len_o);
        end
        checks++;
        if ({data_o, src_ip_o, dst_ip_o} !== 80'd0) begin
            errors++;
            $display("FAIL %s_data: got dat=%h src=%h dst=%h, required all 0", name, data_o, src_ip_o, dst_ip_o);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; valid_i = 1'b0; start_i = 1'b0; crc_err_i = 1'b0;
        data_i = 16'h0000; len_i = 2'd0;
        repeat (3) @(negedge clk);
        check_reset("reset_state");
        reset = 1'b0;

        // Good UDP packet, 95B payload, odd MAC tail
        load_std(16'h0073, 16'h4000, 16'h4011, 16'hb861);
        send_frame(95, 0, 1'b1, -1, 0);
        idle(2);

        // Bad checksum dropped, then a good one (with idle gaps) forwarded
        load_std(16'h0073, 16'h4000, 16'h4011, 16'hb862);
        send_frame(95, 0, 1'b0, -1, 0);
        load_std(16'h0073, 16'h4000, 16'h4011, 16'hb861);
        gap_en = 1'b1;
        send_frame(95, 0, 1'b1, -1, 0);
        gap_en = 1'b0;
        idle(2);

        // TCP protocol and MF set: both dropped
        load_std(16'h0073, 16'h4000, 16'h4006, 16'hb86c);
        send_frame(95, 0, 1'b0, -1, 0);
        load_std(16'h0073, 16'h2000, 16'h4011, 16'hd861);
        send_frame(95, 0, 1'b0, -1, 0);
        idle(2);

        // IHL=6 with one option word pair, 8B payload + FCS
        hdr[0] = 16'h4600; hdr[1] = 16'h0020; hdr[2] = 16'h0000; hdr[3] = 16'h4000;
        hdr[4] = 16'h4011; hdr[5] = 16'hb3ae; hdr[6] = 16'hc0a8; hdr[7] = 16'h0001;
        hdr[8] = 16'hc0a8; hdr[9] = 16'h00c7; hdr[10] = 16'h0102; hdr[11] = 16'h0304;
        hdr_n = 12;
        send_frame(8, 4, 1'b1, -1, 0);
        idle(2);

        // Minimum frame: 26B payload then FCS; late FCS error flags the completed packet
        load_std(16'h002e, 16'h4000, 16'h4011, 16'hb8a6);
        send_frame(26, 4, 1'b1, -1, 0);
        idle(2);
        exp_q.push_back(mk_err());
        crc_pulse();
        crc_pulse();        // fwd cleared: second error ignored
        idle(2);

        // New start in the middle of the payload aborts the old packet
        load_std(16'h0073, 16'h4000, 16'h4011, 16'hb861);
        send_frame(95, 0, 1'b1, 5, 1);
        exp_q.push_back(mk_err());
        send_frame(95, 0, 1'b1, -1, 0);
        idle(2);

        // FCS error during payload: err, no last; trailing beats ignored
        send_frame(95, 0, 1'b1, 3, 1);
        exp_q.push_back(mk_err());
        crc_pulse();
        crc_pulse();
        beat(1'b0, 16'h1234, 2'd2);
        beat(1'b0, 16'h5678, 2'd1);
        idle(2);

        // Truncated MAC frame (1-byte tail while bytes remain)
        send_frame(95, 0, 1'b1, 4, 2);
        idle(2);

        // Reset in the middle of a header
        for (int i = 0; i < 4; i++) beat(i == 0, hdr[i], 2'd2);
        @(negedge clk);
        reset = 1'b1; valid_i = 1'b0; start_i = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("mid_head_reset");
        reset = 1'b0;
        crc_pulse();        // nothing pending after reset
        send_frame(95, 0, 1'b1, -1, 0);
        idle(5);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_outputs: got %0d expected events still pending, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
